// File: rtl/ncm_resp_collector.sv
// ncm_resp_collector: packs NCM core response bits LSB-first into bytes, buffered in a FIFO for a host reader.
// Define NCM_COLL_ONES_EN to add the o_ones count of 1 bits received in the current run.
module ncm_resp_collector #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clkr,
    input  logic       rst_n,
    input  logic       i_start,
    output logic       o_go,
    input  logic       i_q,
    input  logic       i_valid,
    input  logic       i_done,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    input  logic       i_rd_ready,
    output logic       o_busy,
    output logic       o_ovf,
`ifdef NCM_COLL_ONES_EN
    output logic [7:0] o_ones,
`endif
    output logic [7:0] o_nbits
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, WAIT_DN} state_t;
    state_t      st;
    logic [7:0]  shreg;
    logic [2:0]  idx;
    logic [AW:0] wp, rp;
    logic [7:0]  mem [DEPTH];
    logic        full, pop, push_req, push;
    logic [7:0]  push_data;
    assign o_rd_valid = wp != rp;
    assign full       = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop        = o_rd_valid && i_rd_ready;
    assign o_rd_data  = mem[rp[AW-1:0]];
    assign o_busy     = st != IDLE;
    // the flushed partial byte masks stale bits left over from the previous byte
    always_comb begin
        push_req  = (st == RUN && i_valid && idx == 3'd7) || (st == FLUSH && idx != 3'd0);
        push_data = (st == RUN) ? {i_q, shreg[6:0]} : shreg & ~(8'hFF << idx);
        push      = push_req && (!full || pop);
    end
    always_ff @(posedge clkr)
        if (push) mem[wp[AW-1:0]] <= push_data;
    always_ff @(posedge clkr or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            shreg   <= 8'd0;
            idx     <= 3'd0;
            wp      <= '0;
            rp      <= '0;
            o_go    <= 1'b0;
            o_ovf   <= 1'b0;
            o_nbits <= 8'd0;
`ifdef NCM_COLL_ONES_EN
            o_ones  <= 8'd0;
`endif
        end else begin
            if (push) wp <= wp + (AW+1)'(1);
            if (pop) rp <= rp + (AW+1)'(1);
            if (push_req && !push) o_ovf <= 1'b1;
            case (st)
                IDLE: if (i_start) begin
                    o_ovf   <= 1'b0;
                    o_nbits <= 8'd0;
                    idx     <= 3'd0;
                    o_go    <= 1'b1;
                    st      <= RUN;
`ifdef NCM_COLL_ONES_EN
                    o_ones  <= 8'd0;
`endif
                end
                RUN: begin
                    if (i_valid) begin
                        shreg[idx] <= i_q;
                        idx        <= idx + 3'd1;
                        if (o_nbits != 8'hFF) o_nbits <= o_nbits + 8'd1;
`ifdef NCM_COLL_ONES_EN
                        if (i_q && o_ones != 8'hFF) o_ones <= o_ones + 8'd1;
`endif
                    end
                    if (i_done) st <= FLUSH;
                end
                FLUSH: begin
                    idx   <= 3'd0;
                    shreg <= 8'd0;
                    o_go  <= 1'b0;
                    st    <= WAIT_DN;
                end
                WAIT_DN: if (!i_done) st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ncm_resp_collector.sv
// tb_ncm_resp_collector: randomized scoreboard bench for ncm_resp_collector.
// A byte-level reference model feeds an expected queue; a negedge monitor pops and compares.
module tb_ncm_resp_collector;
    localparam int DEPTH = 4;
    logic       clkr = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_q = 1'b0, i_valid = 1'b0;
    logic       i_done = 1'b0, i_rd_ready = 1'b0;
    logic       o_go, o_rd_valid, o_busy, o_ovf;
    logic [7:0] o_rd_data, o_nbits;
`ifdef NCM_COLL_ONES_EN
    logic [7:0] o_ones;
`endif

    ncm_resp_collector #(.DEPTH(DEPTH), .AW(2)) dut (
        .clkr(clkr), .rst_n(rst_n), .i_start(i_start), .o_go(o_go), .i_q(i_q),
        .i_valid(i_valid), .i_done(i_done), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .i_rd_ready(i_rd_ready), .o_busy(o_busy), .o_ovf(o_ovf),
`ifdef NCM_COLL_ONES_EN
        .o_ones(o_ones),
`endif
        .o_nbits(o_nbits)
    );

    always #5 clkr = ~clkr;

    int         n_cmp = 0, n_err = 0;
    logic [7:0] exp_q [$];
    int         occ = 0, m_nbits = 0, m_ones = 0, mi = 0, rdy_pct = 0;
    bit         m_ovf = 0;
    logic [7:0] mb = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock: decide pop/push acceptance from model occupancy, then advance
    task automatic tick(input bit push, input logic [7:0] b);
        bit pop;
        i_rd_ready = ($urandom_range(99) < rdy_pct);
        pop = (occ > 0) && i_rd_ready;
        @(posedge clkr);
        if (push) begin
            if (occ < DEPTH || pop) begin
                exp_q.push_back(b);
                occ++;
            end else m_ovf = 1;
        end
        if (pop) occ--;
        #1;
        i_valid = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic start_run();
        i_start = 1'b1;
        m_ovf = 0; m_nbits = 0; m_ones = 0; mi = 0; mb = 8'd0;
        tick(0, 8'd0);
        chk("go_after_start", o_go, 1);
        chk("busy_after_start", o_busy, 1);
    endtask

    task automatic bit_in(input bit q, input bit done);
        logic [7:0] b;
        i_valid = 1'b1; i_q = q; i_done = done;
        mb[mi] = q; mi++;
        m_nbits = (m_nbits < 255) ? m_nbits + 1 : 255;
        if (q) m_ones = (m_ones < 255) ? m_ones + 1 : 255;
        b = mb;
        if (mi == 8) begin mi = 0; mb = 8'd0; end
        tick(mi == 0, b);
    endtask

    task automatic flush_tail();
        tick(mi != 0, mb);
        mi = 0; mb = 8'd0;
        chk("go_low_after_flush", o_go, 0);
        chk("busy_wait_dn", o_busy, 1);
        chk("nbits", o_nbits, m_nbits);
        chk("ovf", o_ovf, m_ovf);
`ifdef NCM_COLL_ONES_EN
        chk("ones", o_ones, m_ones);
`endif
        repeat ($urandom_range(2)) tick(0, 8'd0);
        i_done = 1'b0;
        tick(0, 8'd0);
        chk("idle_after_done", o_busy, 0);
    endtask

    task automatic end_run();
        i_done = 1'b1;
        tick(0, 8'd0);
        flush_tail();
    endtask

    task automatic drain();
        rdy_pct = 100;
        for (int k = 0; k < 3 * DEPTH && occ > 0; k++) tick(0, 8'd0);
        chk("drained", o_rd_valid, 0);
    endtask

    task automatic rand_run(input int nb, input int pct);
        bit comb;
        rdy_pct = pct;
        start_run();
        comb = 0;
        for (int i = 0; i < nb; i++) begin
            if ($urandom_range(3) == 0) tick(0, 8'd0);
            comb = (i == nb - 1) && $urandom_range(1);
            bit_in($urandom_range(1), comb);
        end
        if (comb) flush_tail(); else end_run();
        drain();
    endtask

    always @(negedge clkr) if (rst_n) begin
        chk("rd_valid", o_rd_valid, occ != 0);
        if (o_rd_valid && i_rd_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL pop_unexpected: got byte %0h expected none", o_rd_data);
            end else chk("rd_data", o_rd_data, exp_q.pop_front());
        end
    end

    initial begin
        logic [7:0] pat;
        repeat (3) @(posedge clkr);
        #1;
        chk("rst_go", o_go, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ovf", o_ovf, 0);
        chk("rst_nbits", o_nbits, 0);
        chk("rst_rd_valid", o_rd_valid, 0);
        rst_n = 1'b1;
        tick(0, 8'd0);
        // basic run: 0x0D then 0xFF
        rdy_pct = 0;
        start_run();
        pat = 8'h0D;
        for (int i = 0; i < 8; i++) bit_in(pat[i], 0);
        for (int i = 0; i < 8; i++) bit_in(1, 0);
        end_run();
        chk("basic_head", o_rd_data, 8'h0D);
        chk("basic_nbits", o_nbits, 16);
        drain();
        // partial byte: 11 ones -> 0xFF, 0x07
        rdy_pct = 0;
        start_run();
        for (int i = 0; i < 11; i++) bit_in(1, 0);
        end_run();
        chk("partial_nbits", o_nbits, 11);
        drain();
        // overflow: 40 bits with no reader
        rdy_pct = 0;
        start_run();
        for (int i = 0; i < 40; i++) bit_in($urandom_range(1), 0);
        end_run();
        chk("ovf_set", o_ovf, 1);
        drain();
        rdy_pct = 0;
        start_run();
        chk("ovf_cleared", o_ovf, 0);
        end_run();
        // full FIFO with simultaneous pop on the 8th bit of the 5th byte
        rdy_pct = 0;
        start_run();
        for (int i = 0; i < 39; i++) bit_in($urandom_range(1), 0);
        rdy_pct = 100;
        bit_in($urandom_range(1), 0);
        rdy_pct = 0;
        end_run();
        chk("full_pop_no_ovf", o_ovf, 0);
        drain();
        // strobe and done together at bit 3
        rdy_pct = 0;
        start_run();
        for (int i = 0; i < 3; i++) bit_in(0, 0);
        bit_in(1, 1);
        flush_tail();
        chk("samecycle_byte", o_rd_data, 8'h08);
        chk("samecycle_nbits", o_nbits, 4);
        drain();
        // reset mid-run
        rdy_pct = 0;
        start_run();
        for (int i = 0; i < 5; i++) bit_in(1, 0);
        rst_n = 1'b0;
        exp_q.delete(); occ = 0; mi = 0; mb = 8'd0;
        #1;
        chk("midrst_go", o_go, 0);
        chk("midrst_rd_valid", o_rd_valid, 0);
        chk("midrst_nbits", o_nbits, 0);
        @(posedge clkr);
        #1;
        rst_n = 1'b1;
        start_run();
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) bit_in(pat[i], 0);
        end_run();
        chk("a5_byte", o_rd_data, 8'hA5);
`ifdef NCM_COLL_ONES_EN
        chk("a5_ones", o_ones, 4);
`endif
        drain();
        // saturation of the bit counter
        rdy_pct = 100;
        start_run();
        for (int i = 0; i < 300; i++) bit_in($urandom_range(1), 0);
        end_run();
        chk("nbits_sat", o_nbits, 255);
        drain();
        for (int r = 0; r < 20; r++) rand_run($urandom_range(1, 50), $urandom_range(100));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
